// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte valid/ready handshake into the UART transmitter FIFO
interface uart_tx_frame_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  modport master (output data_in, output data_valid, input data_ready);
  modport slave (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: FIFO-fed UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_frame #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic s_count,
  output logic tx,
  output logic busy,
  uart_tx_frame_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3, LAST = PARITY;
`else
  localparam logic [2:0] LAST = STOP;
`endif
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_n;
  logic [2:0] state, state_n, cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic push, pop, empty, tx_n;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  assign empty = count == '0;
  assign bus.data_ready = count != FULL;
  assign push = bus.data_valid && bus.data_ready;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  // next-state logic; outputs are registered from the next state so tx lines up with it
  always_comb begin
    pop = !empty && (state == IDLE || (state == STOP && tick));
    state_n = state;
    shift_n = shift;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = pop ? START : IDLE;
      START: state_n = tick ? DATA : START;
      DATA: if (tick) begin
        shift_n = {1'b0, shift[7:1]};
        cnt_n = cnt + 3'd1;
        state_n = (cnt == 3'd7) ? LAST : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = tick ? STOP : PARITY;
`endif
      STOP: if (tick) state_n = pop ? START : IDLE;
      default: state_n = IDLE;
    endcase
    if (pop) begin
      shift_n = mem[rd_ptr];
      cnt_n = '0;
    end
`ifdef UART_TX_PARITY_EN
    par_n = pop ? ^mem[rd_ptr] : par;
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
  // FIFO storage needs no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end
  // state, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      cnt <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tx <= 1'b1;
      s_count <= 1'b0;
      busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      cnt <= cnt_n;
      count <= count_n;
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      tx <= tx_n;
      s_count <= state_n != IDLE;
      busy <= (state_n != IDLE) || (count_n != '0);
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule
